ahb_master: RTL and testbench
=============================

AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, HADDR/cmd_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, HWDATA/HRDATA/wr_data/rsp_rdata width.
REQ-003 SHALL have port HCLK  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port HRESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have port cmd_addr  input  ADDRESS_WIDTH  start address.
REQ-009 SHALL have port cmd_len  input  4  beat count minus one (1..16 beats).
REQ-010 SHALL have port wr_data  input  DATA_WIDTH  write beat data, valid whenever wr_take=1.
REQ-011 SHALL have port wr_take  output  1  pulse: wr_data consumed this cycle.
REQ-012 SHALL have port rsp_valid  output  1  pulse: one beat's data phase completed.
REQ-013 SHALL have ports rsp_rdata  output  DATA_WIDTH (HRDATA captured; 0 on writes), rsp_err  output  1 (HRESP of beat), rsp_last  output  1 (final beat of command).
REQ-014 SHALL have ports HSEL  output  1, HTRANS  output  2, HADDR  output  ADDRESS_WIDTH, HWRITE  output  1, HWDATA  output  DATA_WIDTH.
REQ-015 SHALL have ports HREADY  input  1, HRESP  input  1 (1 = ERROR), HRDATA  input  DATA_WIDTH.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, BURST, LAST_DATA, ERR.
REQ-017 SHALL assert cmd_ready only in IDLE; acceptance latches write, addr, len and moves to ADDR.
REQ-018 SHALL drive HTRANS=NONSEQ (2'b10) in ADDR, SEQ (2'b11) for later beats in BURST, IDLE (2'b00) in IDLE/LAST_DATA/ERR; HSEL = HTRANS[1].
REQ-019 SHALL hold HTRANS/HADDR/HWRITE stable while HREADY=0; address phase completes only on HREADY=1.
REQ-020 SHALL increment HADDR by 1 per accepted address phase, wrapping modulo 2^ADDRESS_WIDTH.
REQ-021 SHALL pipeline: data phase of beat N coincides with address phase of beat N+1.
REQ-022 SHALL, for writes, pulse wr_take and register wr_data into HWDATA on the edge that completes an address phase; HWDATA holds until that data phase completes.
REQ-023 SHALL pulse rsp_valid one cycle after each data phase completes (HREADY=1), with rsp_rdata=HRDATA (reads) and rsp_err=HRESP sampled then.
REQ-024 SHALL transition ADDR->BURST (len>0) or ADDR->LAST_DATA (len=0) on HREADY=1; BURST->LAST_DATA when final address phase accepted; LAST_DATA->IDLE when final data phase completes.
REQ-025 SHALL set rsp_last with the rsp_valid of the final beat, including aborted bursts.
REQ-026 SHALL enter ERR on HRESP=1 with HREADY=0 (first error cycle) and leave ERR per REQ-031/032.
REQ-027 SHALL allow back-to-back commands: cmd_ready asserts the cycle after returning to IDLE.

Reset
REQ-028 SHALL, on HRESET=1, immediately force IDLE, HTRANS=2'b00, HSEL=0, HADDR=0, HWRITE=0, HWDATA=0, cmd_ready=0, wr_take=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_last=0.
REQ-029 SHALL discard any in-flight burst on reset with no response emitted; cmd_ready=1 first cycle after deassertion.

Configuration
REQ-030 SHALL support macro AHB_MASTER_ERR_ABORT_EN.
REQ-031 Defined: in ERR, drive HTRANS=IDLE next cycle, cancel remaining beats, report the erroring beat with rsp_err=1, rsp_last=1, return to IDLE.
REQ-032 Undefined: ERR records the error and resumes remaining beats in order; each beat reports its own rsp_err.

Structure
REQ-033 SHALL place HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and FSM state encodings in shared package ahb_pkg.
REQ-034 SHALL use one sub-module ahb_beat_counter (beats remaining, address increment/wrap).

Verification
REQ-035 Single read: addr=5'h03, len=0, HREADY=1, HRDATA=8'hA5 -> NONSEQ at 03, one rsp_valid, rsp_rdata=A5, rsp_last=1.
REQ-036 4-beat write at 5'h1E, wr_data 11,22,33,44 -> HADDR 1E,1F,00,01 (wrap), HWDATA in order, 4 wr_take pulses.
REQ-037 8-beat read with HREADY=0 for 2 cycles at beat 3 -> HADDR/HTRANS held, 8 responses, no duplicates.
REQ-038 Error on beat 2 of 4 -> macro on: 2 responses, 2nd rsp_err=1, rsp_last=1; macro off: 4 responses, only 2nd rsp_err=1.
REQ-039 HRESET asserted mid-burst -> outputs at reset values same cycle, next command starts NONSEQ cleanly.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer encodings and master FSM state encodings.
package ahb_pkg;

    // AHB HTRANS encodings as seen on the bus.
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    // Master sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_BURST     = 3'd2,
        ST_LAST_DATA = 3'd3,
        ST_ERR       = 3'd4
    } state_t;

    // Width of the beat-count field (beats minus one).
    localparam int LEN_WIDTH = 4;

    // True when the transfer type carries a real address phase.
    function automatic logic trans_active(input htrans_t t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// ahb_beat_counter: tracks the burst address and how many further address
// phases remain after the one currently on the bus.
module ahb_beat_counter
#(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [ADDRESS_WIDTH-1:0] load_addr,
    input  logic [3:0]               load_len,
    input  logic                     advance,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic                     last
);
    import ahb_pkg::*;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    logic [LEN_WIDTH-1:0] left;

    // Load on command acceptance; step address (wrapping naturally) per completed address phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            left <= '0;
        end else if (load) begin
            addr <= load_addr;
            left <= load_len;
        end else if (advance && (left != '0)) begin
            addr <= addr + ADDR_STEP;
            left <= left - 4'd1;
        end
    end

    assign last = (left == '0);

endmodule

// File: rtl/ahb_master.sv
// ahb_master: single-outstanding-command AHB burst master with pipelined
// address/data phases. Optional macro AHB_MASTER_ERR_ABORT_EN: when defined,
// an ERROR response cancels the rest of the burst; otherwise the cancelled
// beat is re-issued as NONSEQ and the burst continues.
module ahb_master
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [3:0]               cmd_len,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_take,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_last,
    output logic                     HSEL,
    output logic [1:0]               HTRANS,
    output logic [ADDRESS_WIDTH-1:0] HADDR,
    output logic                     HWRITE,
    output logic [DATA_WIDTH-1:0]    HWDATA,
    input  logic                     HREADY,
    input  logic                     HRESP,
    input  logic [DATA_WIDTH-1:0]    HRDATA
);
    import ahb_pkg::*;

    state_t  state;
    htrans_t htrans;
    logic    resume_pending;
    logic    accept;
    logic    addr_done;
    logic    last_addr;
    logic    advance;

    assign accept    = cmd_valid && cmd_ready;
    assign addr_done = trans_active(htrans) && HREADY;
    assign advance   = addr_done && !last_addr;
    assign HTRANS    = htrans;
    assign HSEL      = HTRANS[1];
    assign wr_take   = addr_done && HWRITE;

    ahb_beat_counter #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_beat_counter (
        .clk       (HCLK),
        .rst       (HRESET),
        .load      (accept),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .advance   (advance),
        .addr      (HADDR),
        .last      (last_addr)
    );

    // Burst sequencer: drives the bus transfer type and produces one response per completed data phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state          <= ST_IDLE;
            htrans         <= HTRANS_IDLE;
            HWRITE         <= 1'b0;
            HWDATA         <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            rsp_last       <= 1'b0;
            resume_pending <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    htrans <= HTRANS_IDLE;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        HWRITE    <= cmd_write;
                        htrans    <= HTRANS_NONSEQ;
                        state     <= ST_ADDR;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        if (HWRITE) begin
                            HWDATA <= wr_data;
                        end
                        if (last_addr) begin
                            htrans <= HTRANS_IDLE;
                            state  <= ST_LAST_DATA;
                        end else begin
                            htrans <= HTRANS_SEQ;
                            state  <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (HREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= HWRITE ? '0 : HRDATA;
                        rsp_err   <= HRESP;
                        if (HWRITE) begin
                            HWDATA <= wr_data;
                        end
                        if (last_addr) begin
                            htrans <= HTRANS_IDLE;
                            state  <= ST_LAST_DATA;
                        end else begin
                            htrans <= HTRANS_SEQ;
                        end
                    end else if (HRESP) begin
                        htrans         <= HTRANS_IDLE;
                        resume_pending <= 1'b1;
                        state          <= ST_ERR;
                    end
                end
                ST_LAST_DATA: begin
                    if (HREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= HWRITE ? '0 : HRDATA;
                        rsp_err   <= HRESP;
                        rsp_last  <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (HRESP) begin
                        resume_pending <= 1'b0;
                        state          <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    htrans <= HTRANS_IDLE;
                    if (HREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= HWRITE ? '0 : HRDATA;
                        rsp_err   <= 1'b1;
`ifdef AHB_MASTER_ERR_ABORT_EN
                        rsp_last  <= 1'b1;
                        state     <= ST_IDLE;
`else
                        rsp_last  <= !resume_pending;
                        if (resume_pending) begin
                            htrans <= HTRANS_NONSEQ;
                            state  <= ST_ADDR;
                        end else begin
                            state  <= ST_IDLE;
                        end
`endif
                    end
                end
                default: begin
                    htrans <= HTRANS_IDLE;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: scoreboard bench for ahb_master with a scripted AHB slave.
module tb_ahb_master;

    typedef struct packed {
        logic [4:0] addr;
        logic [1:0] trans;
        logic       write;
    } ap_t;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic       last;
    } rsp_t;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [4:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_take;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_last;
    logic       HSEL;
    logic [1:0] HTRANS;
    logic [4:0] HADDR;
    logic       HWRITE;
    logic [7:0] HWDATA;
    logic       HREADY = 1'b1;
    logic       HRESP = 1'b0;
    logic [7:0] HRDATA;

    ap_t        apq[$];
    rsp_t       rspq[$];
    logic [7:0] wdq[$];
    logic [7:0] wdata_arr[16];

    int checks = 0;
    int passes = 0;
    int take_cnt = 0;
    int ap_idx = 0;
    int wr_idx = 0;
    int dp_idx = 0;
    int stall_beat = -1;
    int stall_n = 0;
    int err_beat = -1;
    int wait_left = 0;
    int err_state = 0;
    logic       dp_new = 1'b0;
    logic [4:0] dp_addr = 5'd0;
    logic       hold_pend = 1'b0;
    logic [4:0] hold_addr = 5'd0;
    logic [1:0] hold_trans = 2'd0;
    logic       wd_pend = 1'b0;

    ahb_master #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (8)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_take   (wr_take),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_last  (rsp_last),
        .HSEL      (HSEL),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA)
    );

    always #5 HCLK = ~HCLK;

    // Slave read data is a fixed function of the address in its data phase.
    assign HRDATA  = {3'b000, dp_addr} ^ 8'hA6;
    assign wr_data = wdata_arr[wr_idx[3:0]];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic expAp(input logic [4:0] a, input logic [1:0] t, input logic w);
        ap_t e;
        e.addr  = a;
        e.trans = t;
        e.write = w;
        apq.push_back(e);
    endtask

    task automatic expRsp(input logic [7:0] d, input logic e, input logic l);
        rsp_t r;
        r.rdata = d;
        r.err   = e;
        r.last  = l;
        rspq.push_back(r);
    endtask

    // Plain read burst expectations: incrementing wrapped addresses, data = addr ^ A6.
    task automatic expRead(input logic [4:0] a, input int len);
        logic [4:0] ad;
        for (int i = 0; i <= len; i++) begin
            ad = a + 5'(i);
            expAp(ad, (i == 0) ? 2'b10 : 2'b11, 1'b0);
            expRsp({3'b000, ad} ^ 8'hA6, 1'b0, (i == len));
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [3:0] l);
        int n;
        n = 0;
        @(posedge HCLK); #1;
        ap_idx   = 0;
        wr_idx   = 0;
        take_cnt = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge HCLK); #1;
            n++;
        end
        checkOutput("cmd_ready wait", 32'(cmd_ready), 32'd1);
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (apq.size() == 0 && rspq.size() == 0 && wdq.size() == 0) break;
            @(negedge HCLK); #1;
        end
        checkOutput("drain pending", 32'(apq.size() + rspq.size() + wdq.size()), 32'd0);
        repeat (2) @(posedge HCLK);
    endtask

    // Scripted slave: tracks data phases, inserts wait states and two-cycle ERROR responses.
    always @(posedge HCLK) begin
        logic s_rst, s_rdy, s_act, s_take;
        logic [4:0] s_addr;
        s_rst  = HRESET;
        s_rdy  = HREADY;
        s_act  = HTRANS[1];
        s_addr = HADDR;
        s_take = wr_take;
        #1;
        if (s_rst) begin
            dp_new    = 1'b0;
            err_state = 0;
            wait_left = 0;
            HREADY    = 1'b1;
            HRESP     = 1'b0;
        end else begin
            dp_new = 1'b0;
            if (s_rdy && s_act) begin
                dp_new  = 1'b1;
                dp_addr = s_addr;
                dp_idx  = ap_idx;
                ap_idx++;
            end
            if (s_take) wr_idx++;
            if (err_state == 1) begin
                HREADY    = 1'b1;
                HRESP     = 1'b1;
                err_state = 2;
            end else if (dp_new && dp_idx == err_beat) begin
                HREADY    = 1'b0;
                HRESP     = 1'b1;
                err_state = 1;
            end else if (dp_new && dp_idx == stall_beat) begin
                HREADY    = 1'b0;
                HRESP     = 1'b0;
                wait_left = stall_n - 1;
            end else if (wait_left > 0) begin
                HREADY = 1'b0;
                wait_left--;
            end else begin
                HREADY    = 1'b1;
                HRESP     = 1'b0;
                err_state = 0;
            end
        end
    end

    // Bus monitor: address phases, held signals during wait states, write data, wr_take count.
    always @(posedge HCLK) begin
        ap_t e;
        if (!HRESET) begin
            if (hold_pend) begin
                checkOutput("HADDR held", 32'(HADDR), 32'(hold_addr));
                checkOutput("HTRANS held", 32'(HTRANS), 32'(hold_trans));
            end
            hold_pend  = HTRANS[1] && !HREADY && !HRESP;
            hold_addr  = HADDR;
            hold_trans = HTRANS;
            if (wd_pend && HREADY) begin
                if (wdq.size() == 0) begin
                    checkOutput("spurious write data phase", 32'(HWRITE), 32'd0);
                end else begin
                    checkOutput("HWDATA", 32'(HWDATA), 32'(wdq.pop_front()));
                end
                wd_pend = 1'b0;
            end
            if (HTRANS[1] && HREADY) begin
                if (apq.size() == 0) begin
                    checkOutput("spurious address phase", 32'(HTRANS), 32'd0);
                end else begin
                    e = apq.pop_front();
                    checkOutput("HADDR", 32'(HADDR), 32'(e.addr));
                    checkOutput("HTRANS", 32'(HTRANS), 32'(e.trans));
                    checkOutput("HWRITE", 32'(HWRITE), 32'(e.write));
                    checkOutput("HSEL", 32'(HSEL), 32'd1);
                end
                wd_pend = HWRITE;
            end
            if (wr_take) take_cnt++;
        end else begin
            hold_pend = 1'b0;
            wd_pend   = 1'b0;
        end
    end

    // Response monitor: each rsp_valid pops one expected response.
    always @(negedge HCLK) begin
        rsp_t r;
        if (rsp_valid) begin
            if (rspq.size() == 0) begin
                checkOutput("spurious rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                r = rspq.pop_front();
                checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                checkOutput("rsp_err", 32'(rsp_err), 32'(r.err));
                checkOutput("rsp_last", 32'(rsp_last), 32'(r.last));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        HRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 5'd0;
        cmd_len   = 4'd0;
        for (int i = 0; i < 16; i++) wdata_arr[i] = 8'h00;
        repeat (2) @(posedge HCLK); #1;
        checkOutput("reset HTRANS", 32'(HTRANS), 32'd0);
        checkOutput("reset HSEL", 32'(HSEL), 32'd0);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        HRESET = 1'b0;

        // Single read at 03.
        $display("[TB] single read");
        expAp(5'h03, 2'b10, 1'b0);
        expRsp(8'hA5, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'h03, 4'd0);
        drain();

        // Four-beat write wrapping 1E,1F,00,01.
        $display("[TB] wrapping write burst");
        wdata_arr[0] = 8'h11;
        wdata_arr[1] = 8'h22;
        wdata_arr[2] = 8'h33;
        wdata_arr[3] = 8'h44;
        expAp(5'h1E, 2'b10, 1'b1);
        expAp(5'h1F, 2'b11, 1'b1);
        expAp(5'h00, 2'b11, 1'b1);
        expAp(5'h01, 2'b11, 1'b1);
        wdq.push_back(8'h11);
        wdq.push_back(8'h22);
        wdq.push_back(8'h33);
        wdq.push_back(8'h44);
        expRsp(8'h00, 1'b0, 1'b0);
        expRsp(8'h00, 1'b0, 1'b0);
        expRsp(8'h00, 1'b0, 1'b0);
        expRsp(8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'h1E, 4'd3);
        drain();
        checkOutput("wr_take pulses", 32'(take_cnt), 32'd4);

        // Eight-beat read with two wait states at beat 3.
        $display("[TB] read burst with wait states");
        stall_beat = 3;
        stall_n    = 2;
        expRead(5'h08, 7);
        applyStimulus(1'b0, 5'h08, 4'd7);
        drain();
        stall_beat = -1;

        // Four-beat read with ERROR on the second beat.
        $display("[TB] read burst with error response");
        err_beat = 1;
        expAp(5'h10, 2'b10, 1'b0);
        expAp(5'h11, 2'b11, 1'b0);
        expRsp(8'hB6, 1'b0, 1'b0);
`ifdef AHB_MASTER_ERR_ABORT_EN
        expRsp(8'hB7, 1'b1, 1'b1);
`else
        expRsp(8'hB7, 1'b1, 1'b0);
        expAp(5'h12, 2'b10, 1'b0);
        expAp(5'h13, 2'b11, 1'b0);
        expRsp(8'hB4, 1'b0, 1'b0);
        expRsp(8'hB5, 1'b0, 1'b1);
`endif
        applyStimulus(1'b0, 5'h10, 4'd3);
        drain();
        err_beat = -1;

        // Reset in the middle of a burst, then a clean single read.
        $display("[TB] reset mid-burst");
        expRead(5'h04, 7);
        applyStimulus(1'b0, 5'h04, 4'd7);
        repeat (3) @(posedge HCLK);
        #3;
        HRESET = 1'b1;
        #1;
        checkOutput("mid reset HTRANS", 32'(HTRANS), 32'd0);
        checkOutput("mid reset HSEL", 32'(HSEL), 32'd0);
        checkOutput("mid reset HADDR", 32'(HADDR), 32'd0);
        checkOutput("mid reset HWRITE", 32'(HWRITE), 32'd0);
        checkOutput("mid reset HWDATA", 32'(HWDATA), 32'd0);
        checkOutput("mid reset cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("mid reset wr_take", 32'(wr_take), 32'd0);
        checkOutput("mid reset rsp", 32'({rsp_valid, rsp_err, rsp_last, rsp_rdata}), 32'd0);
        apq.delete();
        rspq.delete();
        wdq.delete();
        @(posedge HCLK); #3;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        checkOutput("cmd_ready after reset", 32'(cmd_ready), 32'd1);
        expRead(5'h1F, 0);
        applyStimulus(1'b0, 5'h1F, 4'd0);
        drain();

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
